// File: rtl/mips_bus_arbiter.sv
// ============================================================================
// Module   : mips_bus_arbiter
// Brief    : Round-robin instruction/data arbiter onto one Avalon-MM bus,
//            with grant locking on stalls and a sticky stall-timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_read,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    output logic        instr_waitrequest,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        data_waitrequest,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic        timeout_error
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    localparam logic [15:0] c_timeout_cycles = 16'(TIMEOUT_CYCLES);

    owner_t      r_owner;
    owner_t      r_last_grant;
    logic [15:0] r_stall_cnt;
    logic        r_timeout;

    owner_t      w_sel;
    owner_t      w_owner_next;
    owner_t      w_last_grant_next;
    logic [15:0] w_stall_next;
    logic        w_timeout_next;
    logic        w_data_req;

    assign w_data_req    = data_read | data_write;
    assign timeout_error = r_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= OWN_NONE;
            r_last_grant <= OWN_DATA;
            r_stall_cnt  <= 16'd0;
            r_timeout    <= 1'b0;
        end else begin
            r_owner      <= w_owner_next;
            r_last_grant <= w_last_grant_next;
            r_stall_cnt  <= w_stall_next;
            r_timeout    <= w_timeout_next;
        end
    end

    always_comb begin
        w_sel             = OWN_NONE;
        w_owner_next      = OWN_NONE;
        w_last_grant_next = r_last_grant;
        w_stall_next      = 16'd0;
        w_timeout_next    = r_timeout;
        address           = 32'd0;
        read              = 1'b0;
        write             = 1'b0;
        byteenable        = 4'd0;
        writedata         = 32'd0;
        instr_readdata    = 32'd0;
        data_readdata     = 32'd0;

        // A locked owner that drops its request loses the bus (no selection).
        case (r_owner)
            OWN_NONE: begin
                if (instr_read && w_data_req)
                    w_sel = (r_last_grant == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
                else if (instr_read)
                    w_sel = OWN_INSTR;
                else if (w_data_req)
                    w_sel = OWN_DATA;
            end
            OWN_INSTR: if (instr_read) w_sel = OWN_INSTR;
            OWN_DATA:  if (w_data_req) w_sel = OWN_DATA;
            default:   w_sel = OWN_NONE;
        endcase

        case (w_sel)
            OWN_INSTR: begin
                address        = instr_address;
                read           = 1'b1;
                byteenable     = 4'b1111;
                instr_readdata = readdata;
            end
            OWN_DATA: begin
                address       = data_address;
                write         = data_write;
                read          = ~data_write;
                byteenable    = data_byteenable;
                writedata     = data_writedata;
                data_readdata = data_write ? 32'd0 : readdata;
            end
            default: ;
        endcase

        instr_waitrequest = instr_read & ((w_sel == OWN_INSTR) ? waitrequest : 1'b1);
        data_waitrequest  = w_data_req & ((w_sel == OWN_DATA)  ? waitrequest : 1'b1);

        if (w_sel != OWN_NONE) begin
            if (waitrequest) begin
                w_owner_next = w_sel;
                w_stall_next = (r_stall_cnt == 16'hFFFF) ? r_stall_cnt : r_stall_cnt + 16'd1;
            end else begin
                w_last_grant_next = w_sel;
            end
        end

        if (w_stall_next == c_timeout_cycles)
            w_timeout_next = 1'b1;
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
// ============================================================================
// Module   : tb_mips_bus_arbiter
// Brief    : Scoreboard bench for mips_bus_arbiter (TIMEOUT_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_read;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        instr_waitrequest;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [3:0]  data_byteenable;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        data_waitrequest;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        timeout_error;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        iw;
        logic        dw;
        logic [31:0] ird;
        logic [31:0] drd;
        logic        to;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    mips_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .instr_read        (instr_read),
        .instr_address     (instr_address),
        .instr_readdata    (instr_readdata),
        .instr_waitrequest (instr_waitrequest),
        .data_read         (data_read),
        .data_write        (data_write),
        .data_address      (data_address),
        .data_byteenable   (data_byteenable),
        .data_writedata    (data_writedata),
        .data_readdata     (data_readdata),
        .data_waitrequest  (data_waitrequest),
        .address           (address),
        .read              (read),
        .write             (write),
        .byteenable        (byteenable),
        .writedata         (writedata),
        .readdata          (readdata),
        .waitrequest       (waitrequest),
        .timeout_error     (timeout_error)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t e_idle(input logic to);
        exp_t e;
        e = '{addr: 32'd0, rd: 1'b0, wr: 1'b0, be: 4'd0, wd: 32'd0,
              iw: 1'b0, dw: 1'b0, ird: 32'd0, drd: 32'd0, to: to};
        return e;
    endfunction

    function automatic exp_t e_instr(input logic [31:0] a, input logic [31:0] rdd,
                                     input logic iw, input logic dw, input logic to);
        exp_t e;
        e = '{addr: a, rd: 1'b1, wr: 1'b0, be: 4'hF, wd: 32'd0,
              iw: iw, dw: dw, ird: rdd, drd: 32'd0, to: to};
        return e;
    endfunction

    function automatic exp_t e_data(input logic [31:0] a, input logic rd, input logic wr,
                                    input logic [3:0] be, input logic [31:0] wd,
                                    input logic [31:0] drd, input logic iw, input logic dw,
                                    input logic to);
        exp_t e;
        e = '{addr: a, rd: rd, wr: wr, be: be, wd: wd,
              iw: iw, dw: dw, ird: 32'd0, drd: drd, to: to};
        return e;
    endfunction

    // Queue the expectation for the stimulus already driven, compare mid-cycle,
    // then advance to just after the next rising edge.
    task automatic step(input string tag, input exp_t e);
        exp_t  x;
        string t;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        x = sb_q.pop_front();
        t = tag_q.pop_front();
        check_eq({t, ".address"},    address,                  x.addr);
        check_eq({t, ".read"},       {31'd0, read},            {31'd0, x.rd});
        check_eq({t, ".write"},      {31'd0, write},           {31'd0, x.wr});
        check_eq({t, ".byteenable"}, {28'd0, byteenable},      {28'd0, x.be});
        check_eq({t, ".writedata"},  writedata,                x.wd);
        check_eq({t, ".instr_wait"}, {31'd0, instr_waitrequest}, {31'd0, x.iw});
        check_eq({t, ".data_wait"},  {31'd0, data_waitrequest},  {31'd0, x.dw});
        check_eq({t, ".instr_rd"},   instr_readdata,           x.ird);
        check_eq({t, ".data_rd"},    data_readdata,            x.drd);
        check_eq({t, ".timeout"},    {31'd0, timeout_error},   {31'd0, x.to});
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        instr_read      = 1'b0;
        instr_address   = 32'd0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        data_address    = 32'd0;
        data_byteenable = 4'd0;
        data_writedata  = 32'd0;
        readdata        = 32'd0;
        waitrequest     = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        step("reset", e_idle(1'b0));
        reset = 1'b0;

        // Single fetch, zero wait states.
        instr_read    = 1'b1;
        instr_address = 32'hBFC0_0000;
        readdata      = 32'h2402_0005;
        step("fetch", e_instr(32'hBFC0_0000, 32'h2402_0005, 1'b0, 1'b0, 1'b0));
        clear_inputs();

        // last_grant=INSTR, so DATA wins the tie and then holds through stalls.
        instr_read      = 1'b1;
        instr_address   = 32'h0000_0400;
        data_write      = 1'b1;
        data_address    = 32'h0000_1000;
        data_byteenable = 4'b0011;
        data_writedata  = 32'hDEAD_BEEF;
        readdata        = 32'h1111_1111;
        waitrequest     = 1'b1;
        for (int i = 0; i < 3; i++)
            step($sformatf("lock%0d", i),
                 e_data(32'h1000, 1'b0, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1, 1'b0));
        waitrequest = 1'b0;
        step("lock_done",
             e_data(32'h1000, 1'b0, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0, 1'b0));
        readdata = 32'h2222_2222;
        step("after_lock", e_instr(32'h400, 32'h2222_2222, 1'b0, 1'b1, 1'b0));
        clear_inputs();

        // Read and write together: write wins, no load data returned.
        data_read       = 1'b1;
        data_write      = 1'b1;
        data_address    = 32'h0000_2000;
        data_byteenable = 4'hF;
        data_writedata  = 32'h0BAD_F00D;
        readdata        = 32'hCAFE_F00D;
        step("rw_both", e_data(32'h2000, 1'b0, 1'b1, 4'hF, 32'h0BAD_F00D, 32'd0, 1'b0, 1'b0, 1'b0));
        data_write = 1'b0;
        step("data_rd", e_data(32'h2000, 1'b1, 1'b0, 4'hF, 32'h0BAD_F00D, 32'hCAFE_F00D,
                               1'b0, 1'b0, 1'b0));
        clear_inputs();

        // Alternation after reset: INSTR first.
        reset = 1'b1;
        step("rr_reset", e_idle(1'b0));
        reset = 1'b0;
        instr_read      = 1'b1;
        instr_address   = 32'h0000_0100;
        data_read       = 1'b1;
        data_address    = 32'h0000_0200;
        data_byteenable = 4'hC;
        data_writedata  = 32'h0000_0055;
        for (int i = 0; i < 4; i++) begin
            readdata = 32'hA000_0000 + 32'(i);
            if (i % 2 == 0)
                step($sformatf("rr%0d", i), e_instr(32'h100, readdata, 1'b0, 1'b1, 1'b0));
            else
                step($sformatf("rr%0d", i),
                     e_data(32'h200, 1'b1, 1'b0, 4'hC, 32'h55, readdata, 1'b1, 1'b0, 1'b0));
        end
        clear_inputs();

        // Timeout after the 4th stalled cycle, sticky once the stall ends.
        instr_read    = 1'b1;
        instr_address = 32'h0000_0300;
        readdata      = 32'h0000_0033;
        waitrequest   = 1'b1;
        for (int i = 0; i < 4; i++)
            step($sformatf("stall%0d", i), e_instr(32'h300, 32'h33, 1'b1, 1'b0, 1'b0));
        waitrequest = 1'b0;
        step("to_set", e_instr(32'h300, 32'h33, 1'b0, 1'b0, 1'b1));
        clear_inputs();
        step("to_sticky", e_idle(1'b1));

        // Reset in the middle of a locked data transfer.
        data_write      = 1'b1;
        data_address    = 32'h0000_1000;
        data_byteenable = 4'b0011;
        data_writedata  = 32'h1234_5678;
        waitrequest     = 1'b1;
        step("pre_abort", e_data(32'h1000, 1'b0, 1'b1, 4'b0011, 32'h1234_5678, 32'd0,
                                 1'b0, 1'b1, 1'b1));
        clear_inputs();
        reset = 1'b1;
        step("abort_reset", e_idle(1'b0));
        reset = 1'b0;
        instr_read      = 1'b1;
        instr_address   = 32'h0000_0100;
        data_read       = 1'b1;
        data_address    = 32'h0000_0200;
        data_byteenable = 4'hF;
        readdata        = 32'h0000_0066;
        step("post_reset0", e_instr(32'h100, 32'h66, 1'b0, 1'b1, 1'b0));
        step("post_reset1", e_data(32'h200, 1'b1, 1'b0, 4'hF, 32'd0, 32'h66, 1'b1, 1'b0, 1'b0));
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
